// File: rtl/llr_dibit_packer_pkg.sv
// Shared definitions for the LLR dibit packer: X1 seed, FSM states and the
// soft-bit width conversion.
// Optional feature macro: LLR_PACK_SAT_EN (symmetric saturation instead of
// dropping LSBs).
package llr_dibit_packer_pkg;

  localparam logic [30:0] X1_INIT = 31'h0000_0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PACK  = 2'd2,
    FLUSH = 2'd3
  } pack_state_t;

`ifdef LLR_PACK_SAT_EN
  // Keep the LSBs and clamp symmetrically so the most-negative code never
  // appears (downstream negation stays in range).
  function automatic logic signed [31:0] llr_convert(input logic signed [31:0] llr,
                                                     input int out_w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    if (llr > lim) begin
      llr_convert = lim;
    end else if (llr < -lim) begin
      llr_convert = -lim;
    end else begin
      llr_convert = llr;
    end
  endfunction
`else
  // Drop LSBs with an arithmetic shift; the caller keeps the low bits, which
  // are the original MSBs.
  function automatic logic signed [31:0] llr_convert(input logic signed [31:0] llr,
                                                     input int drop_lsbs);
    llr_convert = llr >>> drop_lsbs;
  endfunction
`endif

endpackage

// File: rtl/llr_width_conv.sv
// Combinational soft-bit width conversion (truncate, or saturate when
// LLR_PACK_SAT_EN is defined). Shared by other soft-bit paths.
module llr_width_conv
  import llr_dibit_packer_pkg::*;
#(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [IN_WIDTH-1:0]  raw_llr,
  output logic signed [OUT_WIDTH-1:0] conv_llr
);

`ifdef LLR_PACK_SAT_EN
  assign conv_llr = OUT_WIDTH'(llr_convert(32'(raw_llr), OUT_WIDTH));
`else
  assign conv_llr = OUT_WIDTH'(llr_convert(32'(raw_llr), IN_WIDTH - OUT_WIDTH));
`endif

endmodule

// File: rtl/llr_dibit_packer.sv
// Packs one LLR per clock into even/odd pairs for the two-LLR-per-clock
// descrambler, issues the per-block sequence start with X1/X2 seeds, pads
// odd-length blocks and flags protocol errors.
// Optional feature macro: LLR_PACK_SAT_EN (handled in llr_width_conv).
module llr_dibit_packer
  import llr_dibit_packer_pkg::*;
#(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                        i_clk_2x,
  input  logic                        i_rstn,
  input  logic                        i_sof,
  input  logic [30:0]                 i_c_init,
  input  logic [LEN_WIDTH-1:0]        i_blk_len,
  input  logic signed [IN_WIDTH-1:0]  i_data,
  input  logic                        i_strb,
  output logic                        o_start,
  output logic [30:0]                 o_x1_init,
  output logic [30:0]                 o_x2_init,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic signed [OUT_WIDTH-1:0] o_data2,
  output logic                        o_strb,
  output logic                        o_eob,
  output logic                        o_busy,
  output logic                        o_err
);

  pack_state_t                 state_r, state_nxt_s;
  logic [LEN_WIDTH-1:0]        cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [LEN_WIDTH-1:0]        len_r, len_nxt_s;
  logic signed [OUT_WIDTH-1:0] hold_r, hold_nxt_s;
  logic signed [OUT_WIDTH-1:0] conv_s;
  logic signed [OUT_WIDTH-1:0] data_nxt_s, data2_nxt_s;
  logic [30:0]                 x1_nxt_s, x2_nxt_s;
  logic                        start_nxt_s, strb_nxt_s, eob_nxt_s, err_nxt_s, busy_nxt_s;

  llr_width_conv #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_conv (
    .raw_llr (i_data),
    .conv_llr(conv_s)
  );

  assign cnt_inc_s = cnt_r + LEN_WIDTH'(1'b1);

  // Next-state, counter/hold and next-output decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    len_nxt_s   = len_r;
    hold_nxt_s  = hold_r;
    x1_nxt_s    = o_x1_init;
    x2_nxt_s    = o_x2_init;
    data_nxt_s  = o_data;
    data2_nxt_s = o_data2;
    start_nxt_s = 1'b0;
    strb_nxt_s  = 1'b0;
    eob_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;

    if (i_sof) begin
      // A new block always wins; a strobe in the same cycle is dropped quietly.
      err_nxt_s  = (state_r != IDLE) || (i_blk_len == '0);
      cnt_nxt_s  = '0;
      hold_nxt_s = '0;
      if (i_blk_len != '0) begin
        len_nxt_s   = i_blk_len;
        x1_nxt_s    = X1_INIT;
        x2_nxt_s    = i_c_init;
        start_nxt_s = 1'b1;
        state_nxt_s = START;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          err_nxt_s = i_strb;
        end
        START, PACK: begin
          state_nxt_s = PACK;
          if (i_strb) begin
            cnt_nxt_s = cnt_inc_s;
            if (cnt_r[0] == 1'b0) begin
              hold_nxt_s = conv_s;
            end else begin
              data_nxt_s  = hold_r;
              data2_nxt_s = conv_s;
              strb_nxt_s  = 1'b1;
            end
            if (cnt_inc_s == len_r) begin
              // Even length closes on this pair; odd length pads in FLUSH.
              eob_nxt_s   = cnt_r[0];
              state_nxt_s = cnt_r[0] ? IDLE : FLUSH;
            end else begin
              state_nxt_s = PACK;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        FLUSH: begin
          // Emitting from FLUSH keeps a one-LLR block's pair two cycles
          // behind its start pulse.
          data_nxt_s  = hold_r;
          data2_nxt_s = '0;
          strb_nxt_s  = 1'b1;
          eob_nxt_s   = 1'b1;
          err_nxt_s   = i_strb;
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end

    busy_nxt_s = (state_nxt_s != IDLE) || strb_nxt_s;
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge i_clk_2x or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      len_r     <= '0;
      hold_r    <= '0;
      o_start   <= 1'b0;
      o_x1_init <= 31'h0000_0000;
      o_x2_init <= 31'h0000_0000;
      o_data    <= '0;
      o_data2   <= '0;
      o_strb    <= 1'b0;
      o_eob     <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      len_r     <= len_nxt_s;
      hold_r    <= hold_nxt_s;
      o_start   <= start_nxt_s;
      o_x1_init <= x1_nxt_s;
      o_x2_init <= x2_nxt_s;
      o_data    <= data_nxt_s;
      o_data2   <= data2_nxt_s;
      o_strb    <= strb_nxt_s;
      o_eob     <= eob_nxt_s;
      o_busy    <= busy_nxt_s;
      o_err     <= err_nxt_s;
    end
  end

endmodule

// File: doc/llr_dibit_packer.md
Name: llr_dibit_packer

Overview:
- Upstream feeder for the two-LLR-per-clock golden-sequence descrambler.
- Accepts one soft LLR per i_clk_2x cycle and packs consecutive LLRs into even/odd pairs (o_data = 0th,2nd,4th…; o_data2 = 1st,3rd,5th…).
- Per transport block, issues the descrambler's sequence-start pulse with the X1/X2 initial values, pads odd-length blocks, flags end of block, and flags protocol errors.

Parameters:
- IN_WIDTH, 10, input LLR width (signed).
- OUT_WIDTH, 8, output LLR width (signed); must be <= IN_WIDTH.
- LEN_WIDTH, 16, width of the block-length field.

Ports:
- i_clk_2x  input  1  block clock; one input LLR per cycle max.
- i_rstn  input  1  asynchronous reset, active low.
- i_sof  input  1  block start pulse; samples i_c_init and i_blk_len.
- i_c_init  input  31  scrambling c_init for the block.
- i_blk_len  input  LEN_WIDTH  number of LLRs in block.
- i_data  input  IN_WIDTH  signed LLR.
- i_strb  input  1  i_data valid.
- o_start  output  1  one-cycle sequence-init pulse to descrambler.
- o_x1_init  output  31  X1 initial value, constant 31'h0000_0001 once loaded.
- o_x2_init  output  31  X2 initial value = latched c_init.
- o_data  output  OUT_WIDTH  even-index LLR.
- o_data2  output  OUT_WIDTH  odd-index LLR (0 for pad).
- o_strb  output  1  pair valid.
- o_eob  output  1  coincides with last o_strb of block.
- o_busy  output  1  high from accepted i_sof until last pair is output.
- o_err  output  1  one-cycle error pulse.

Behaviour:
- Clock and reset: single clock i_clk_2x; asynchronous active-low reset i_rstn. The reset applies to all state; a reset mid-block discards the block silently.
- Reset values:
  - all outputs 0, except o_x1_init = 0 and o_x2_init = 0;
  - FSM in IDLE; counter and hold register cleared.
- FSM states:
  - IDLE: o_busy = 0. On i_sof with i_blk_len != 0, latch c_init and len, clear the counter, go to START. On i_sof with len == 0, pulse o_err and stay in IDLE. i_strb in IDLE: drop the LLR and pulse o_err.
  - START: one cycle. Drives o_start = 1 and presents o_x1_init = 1 and o_x2_init = c_init, both registered and held until the next accepted i_sof. Goes to PACK. An i_strb in this cycle is accepted as LLR index 0.
  - PACK: each i_strb converts the LLR and increments the counter.
    - Even index: store the LLR in the hold register.
    - Odd index: the next cycle drives o_data = hold, o_data2 = LLR, o_strb = 1.
    - The pair therefore appears one cycle after its second LLR.
    - When counter reaches len and len is even, go to IDLE with o_eob on that pair's o_strb.
    - When len is odd, the last LLR goes to FLUSH.
  - FLUSH: one cycle. Drives o_data = hold, o_data2 = 0, o_strb = 1, o_eob = 1, then IDLE. An i_strb in FLUSH is dropped and o_err pulses.
- Latency and spacing:
  - o_start is one cycle after i_sof.
  - The earliest o_strb is 2 cycles after o_start, so o_start and o_strb never coincide. This is a hard requirement, because the descrambler gives start priority over strobe.
- i_sof while in START, PACK or FLUSH:
  - abort the block: pulse o_err and discard the hold register;
  - no o_eob is issued for the aborted block;
  - restart with the new parameters (START next cycle).
  - i_strb in the same cycle as i_sof is dropped with no error.
- o_data and o_data2 hold their last value while o_strb = 0.
- Width conversion: without the optional feature, output = i_data[IN_WIDTH-1 -: OUT_WIDTH] (arithmetic truncation of LSBs).

Optional Feature:
- Macro LLR_PACK_SAT_EN.
- When defined: output = i_data >>> 0, symmetric-saturated to ±(2^(OUT_WIDTH-1)-1), keeping the LSBs. The most-negative code is never emitted, so downstream negation cannot overflow. A saturated sample does not raise o_err.
- When undefined: MSB truncation as above; the most-negative code can be emitted.

Decomposition:
- Shared package: X1_INIT constant (31'h1), FSM state enum {IDLE, START, PACK, FLUSH}, and an LLR width-conversion function (truncate or saturate under the macro).
- One natural sub-module: llr_width_conv, the combinational truncate/saturate stage, reused by other soft-bit paths.
- Counter, hold register and FSM stay in the top module.

Test Plan:
- Even block: i_sof with c_init = 31'h1234_5678 and len = 4, then LLRs 1, 2, 3, 4 on consecutive cycles.
  - o_start pulses once with o_x2_init = 31'h1234_5678 and o_x1_init = 1.
  - Pairs (1,2) then (3,4); o_eob on (3,4).
- Odd block with gaps: len = 3, LLRs 5, -6, 7 with idle cycles between them.
  - Pairs (5,-6), then (7,0) with o_eob.
  - o_busy drops the cycle after o_eob.
- Errors:
  - len = 0 gives an o_err pulse and no o_start.
  - i_strb in IDLE gives an o_err pulse and no o_strb.
- Abort: i_sof mid-block after 3 of 8 LLRs gives an o_err pulse, a new o_start with the new c_init, and no o_eob for the old block.
- Width conversion: input 10'sh1FF and 10'sh200.
  - Without macro: 8'sh7F and 8'sh80.
  - With LLR_PACK_SAT_EN: 8'sh7F and 8'sh81.
  - Input 10'sh005 gives 8'sh05 with the macro and 8'sh01 without it.
- Reset: assert i_rstn = 0 during PACK. All outputs read 0 immediately (asynchronous), and after release the next block behaves normally.
